// File: rtl/t1_mem_3r3w_resp_pkg.sv
// Shared types for the 3-read/3-write memory with response pipelines.
//   state_e    : controller state (INIT sweep, RUN)
//   rd_stage_t : one read-pipeline stage (valid flag plus data)
// Stage data is sized to MAX_WIDTH so the struct can be shared by any
// WIDTH <= MAX_WIDTH; unused upper bits are always zero.
package t1_mem_3r3w_resp_pkg;

   localparam int unsigned MAX_WIDTH = 64;

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   typedef struct packed {
      logic                 valid;
      logic [MAX_WIDTH-1:0] data;
   } rd_stage_t;

endpackage

// File: rtl/t1_mem_3r3w_resp_if.sv
// Bus bundle for t1_mem_3r3w_resp.
//   read ports D/E/F  : t1_readX, t1_addrX -> t1_doutX, t1_vldX
//   write ports A/B/C : t1_writeY, t1_addrY, t1_dinY, t1_bwY
//   status            : ready (init done), coll (write collision), err (illegal access)
// master = requester side, slave = memory side.
interface t1_mem_3r3w_resp_if #(
   parameter int unsigned WIDTH   = 15,
   parameter int unsigned BITADDR = 8
);
   logic               t1_readD, t1_readE, t1_readF;
   logic [BITADDR-1:0] t1_addrD, t1_addrE, t1_addrF;
   logic [WIDTH-1:0]   t1_doutD, t1_doutE, t1_doutF;
   logic               t1_vldD, t1_vldE, t1_vldF;

   logic               t1_writeA, t1_writeB, t1_writeC;
   logic [BITADDR-1:0] t1_addrA, t1_addrB, t1_addrC;
   logic [WIDTH-1:0]   t1_dinA, t1_dinB, t1_dinC;
   logic [WIDTH-1:0]   t1_bwA, t1_bwB, t1_bwC;

   logic               ready, coll, err;

   modport master (
      output t1_readD, t1_readE, t1_readF, t1_addrD, t1_addrE, t1_addrF,
      output t1_writeA, t1_writeB, t1_writeC, t1_addrA, t1_addrB, t1_addrC,
      output t1_dinA, t1_dinB, t1_dinC, t1_bwA, t1_bwB, t1_bwC,
      input  t1_doutD, t1_doutE, t1_doutF, t1_vldD, t1_vldE, t1_vldF,
      input  ready, coll, err
   );

   modport slave (
      input  t1_readD, t1_readE, t1_readF, t1_addrD, t1_addrE, t1_addrF,
      input  t1_writeA, t1_writeB, t1_writeC, t1_addrA, t1_addrB, t1_addrC,
      input  t1_dinA, t1_dinB, t1_dinC, t1_bwA, t1_bwB, t1_bwC,
      output t1_doutD, t1_doutE, t1_doutF, t1_vldD, t1_vldE, t1_vldF,
      output ready, coll, err
   );
endinterface

// File: rtl/t1_mem_3r3w_resp_rd_pipe.sv
// t1_rd_pipe: DELAY-deep valid/data shift register for one read port.
//   clk, rst           : clock, asynchronous active-high reset (clears all stages)
//   in_valid, in_data  : read result captured this cycle
//   out_valid, out_data: result DELAY cycles later; data is 0 when not valid
module t1_rd_pipe
   import t1_mem_3r3w_resp_pkg::*;
#(
   parameter int unsigned WIDTH = 15,
   parameter int unsigned DELAY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   rd_stage_t stage_q [DELAY];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DELAY); i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0].valid <= in_valid;
         stage_q[0].data  <= in_valid ? MAX_WIDTH'(in_data) : '0;
         for (int i = 1; i < int'(DELAY); i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign out_valid = stage_q[DELAY-1].valid;
   assign out_data  = stage_q[DELAY-1].data[WIDTH-1:0];

endmodule

// File: rtl/t1_mem_3r3w_resp.sv
// t1_mem_3r3w_resp: NUMADDR x WIDTH memory, 3 read ports (D/E/F) with
// T1_DELAY-cycle pipelined responses, 3 bit-masked write ports (A/B/C).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of t1_mem_3r3w_resp_if (reads, writes, ready/coll/err)
// After reset the array is swept to zero (INIT); ready rises once in RUN.
module t1_mem_3r3w_resp
   import t1_mem_3r3w_resp_pkg::*;
#(
   parameter int unsigned WIDTH    = 15,
   parameter int unsigned BITADDR  = 8,
   parameter int unsigned NUMADDR  = 256,
   parameter int unsigned T1_DELAY = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   t1_mem_3r3w_resp_if.slave    bus
);

   localparam logic [BITADDR:0] NUM_LIM = (BITADDR+1)'(NUMADDR);

   logic [WIDTH-1:0]   mem [NUMADDR];

   state_e             state_q, state_d;
   logic [BITADDR:0]   cnt_q, cnt_d;
   logic               init_we;
   logic               coll_q, coll_d, err_q, err_d;

   logic [2:0]         rd_req, wr_req, rd_ok, wr_ok, rd_bad, wr_bad, rd_vld;
   logic [BITADDR-1:0] rd_addr [3];
   logic [BITADDR-1:0] wr_addr [3];
   logic [WIDTH-1:0]   wr_din [3];
   logic [WIDTH-1:0]   wr_bw [3];
   logic [WIDTH-1:0]   wr_word [3];
   logic [WIDTH-1:0]   rd_word [3];
   logic [WIDTH-1:0]   rd_dout [3];
   logic               run;

   assign run = (state_q == RUN);

   // Index 0/1/2 = D/E/F for reads, A/B/C for writes (C has highest priority).
   assign rd_req     = {bus.t1_readF, bus.t1_readE, bus.t1_readD};
   assign rd_addr[0] = bus.t1_addrD;
   assign rd_addr[1] = bus.t1_addrE;
   assign rd_addr[2] = bus.t1_addrF;
   assign wr_req     = {bus.t1_writeC, bus.t1_writeB, bus.t1_writeA};
   assign wr_addr[0] = bus.t1_addrA;
   assign wr_addr[1] = bus.t1_addrB;
   assign wr_addr[2] = bus.t1_addrC;
   assign wr_din[0]  = bus.t1_dinA;
   assign wr_din[1]  = bus.t1_dinB;
   assign wr_din[2]  = bus.t1_dinC;
   assign wr_bw[0]   = bus.t1_bwA;
   assign wr_bw[1]   = bus.t1_bwB;
   assign wr_bw[2]   = bus.t1_bwC;

   // Access qualification and per-port merged write word.
   always_comb begin
      for (int p = 0; p < 3; p++) begin
         rd_bad[p]  = rd_req[p] && ({1'b0, rd_addr[p]} >= NUM_LIM);
         wr_bad[p]  = wr_req[p] && ({1'b0, wr_addr[p]} >= NUM_LIM);
         rd_ok[p]   = run && rd_req[p] && !rd_bad[p];
         wr_ok[p]   = run && wr_req[p] && !wr_bad[p];
         rd_word[p] = rd_ok[p] ? mem[rd_addr[p]] : '0;
      end
      // Every port targeting the same address computes the same merged word,
      // applying A then B then C, so per-bit priority is C > B > A.
      for (int p = 0; p < 3; p++) begin
         wr_word[p] = mem[wr_addr[p]];
         for (int q = 0; q < 3; q++) begin
            if (wr_ok[q] && (wr_addr[q] == wr_addr[p])) begin
               wr_word[p] = (wr_word[p] & ~wr_bw[q]) | (wr_din[q] & wr_bw[q]);
            end
         end
      end
   end

   // FSM next state and status pulses.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      init_we = 1'b0;
      case (state_q)
         INIT: begin
            if (cnt_q < NUM_LIM) begin
               init_we = 1'b1;
               cnt_d   = cnt_q + 1'b1;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
         end
      endcase
      err_d  = run ? |{rd_bad, wr_bad} : |{rd_req, wr_req};
      coll_d = (wr_ok[0] && wr_ok[1] && (wr_addr[0] == wr_addr[1])) ||
               (wr_ok[0] && wr_ok[2] && (wr_addr[0] == wr_addr[2])) ||
               (wr_ok[1] && wr_ok[2] && (wr_addr[1] == wr_addr[2]));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
         coll_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         coll_q  <= coll_d;
         err_q   <= err_d;
      end
   end

   // Array has no reset; the INIT sweep clears it.
   always_ff @(posedge clk) begin
      if (init_we) begin
         mem[cnt_q[BITADDR-1:0]] <= '0;
      end
      for (int p = 0; p < 3; p++) begin
         if (wr_ok[p]) begin
            mem[wr_addr[p]] <= wr_word[p];
         end
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_rd
      t1_rd_pipe #(
         .WIDTH (WIDTH),
         .DELAY (T1_DELAY)
      ) u_rd_pipe (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (rd_ok[g]),
         .in_data   (rd_word[g]),
         .out_valid (rd_vld[g]),
         .out_data  (rd_dout[g])
      );
   end

   assign bus.t1_vldD  = rd_vld[0];
   assign bus.t1_vldE  = rd_vld[1];
   assign bus.t1_vldF  = rd_vld[2];
   assign bus.t1_doutD = rd_dout[0];
   assign bus.t1_doutE = rd_dout[1];
   assign bus.t1_doutF = rd_dout[2];
   assign bus.ready    = run;
   assign bus.coll     = coll_q;
   assign bus.err      = err_q;

endmodule

// File: doc/t1_mem_3r3w_resp.md
T1_MEM_3R3W_RESP -- requirements
Module: t1_mem_3r3w_resp

Interface
REQ-001 The module SHALL have parameter WIDTH, default 15, meaning data and bit-write width.
REQ-002 The module SHALL have parameter BITADDR, default 8, meaning address width.
REQ-003 The module SHALL have parameter NUMADDR, default 256, meaning number of words (<= 2**BITADDR).
REQ-004 The module SHALL have parameter T1_DELAY, default 2, meaning read latency in cycles (>= 1).
REQ-005 The module SHALL have ports: clk input 1, the single clock; rst input 1, reset (asynchronous, active-high).
REQ-006 The module SHALL have ports for each read port X in {D,E,F}: t1_readX input 1, read strobe; t1_addrX input BITADDR, read address; t1_doutX output WIDTH, read data; t1_vldX output 1, read data valid.
REQ-007 The module SHALL have ports for each write port Y in {A,B,C}: t1_writeY input 1, write strobe; t1_addrY input BITADDR, write address; t1_dinY input WIDTH, write data; t1_bwY input WIDTH, per-bit write enable.
REQ-008 The module SHALL have ports: ready output 1, init complete; coll output 1, same-address write collision pulse; err output 1, illegal-access pulse.

Function
REQ-009 The module SHALL contain an FSM with states INIT and RUN, entered as INIT on reset.
REQ-010 In INIT, the module SHALL write all-zero to address cnt and increment cnt once per cycle; after writing NUMADDR-1 it SHALL go to RUN in the next cycle; ready SHALL be 1 only in RUN.
REQ-011 In INIT, all t1_read/t1_write strobes SHALL be ignored, and any asserted strobe SHALL pulse err for one cycle, registered one cycle later.
REQ-012 In RUN, a write SHALL update the word as mem[a] = (mem[a] & ~bw) | (din & bw).
REQ-013 When two or more writes target the same address in one cycle, bits SHALL be resolved per bit with priority C > B > A, and coll SHALL pulse 1, registered one cycle later.
REQ-014 A read sampled at cycle t SHALL return the array contents before the writes of cycle t (read-before-write).
REQ-015 A read sampled at cycle t SHALL drive t1_doutX and t1_vldX=1 exactly at cycle t+T1_DELAY.
REQ-016 Reads SHALL be fully pipelined: one read per port per cycle, with no stalls.
REQ-017 When t1_vldX=0, t1_doutX SHALL be 0.
REQ-018 Any access with address >= NUMADDR SHALL be dropped (no write, and vld SHALL stay 0 for that read), and err SHALL pulse one cycle later.
REQ-019 err and coll SHALL be ORed across ports, and SHALL be one-cycle pulses, not sticky.
REQ-020 A read and a write to the same address in the same cycle SHALL NOT raise coll.

Reset
REQ-021 Asserting rst SHALL asynchronously force: state INIT, cnt 0, ready 0, coll 0, err 0, all t1_vldX 0, all t1_doutX 0, all read pipeline stages invalid.
REQ-022 Reset mid-operation SHALL discard in-flight reads, so that no vld is produced for reads issued before reset.
REQ-023 Array contents SHALL NOT be reset directly; they SHALL be cleared by the INIT sweep after rst deasserts.

Structure
REQ-024 A shared package SHALL hold the FSM state enum (INIT, RUN) and the read-pipeline stage struct (valid, data).
REQ-025 One sub-module, t1_rd_pipe (T1_DELAY-deep valid/data shift register with async reset), SHALL be instantiated once per read port.
REQ-026 The storage array, write-merge logic, collision detect and FSM SHALL reside in the top module.

Verification
REQ-027 Init: release rst, then hold all strobes 0 -> ready rises exactly NUMADDR+1 cycles after release (257 for defaults); a read of addr 0x05 then returns 0 with vld 2 cycles later.
REQ-028 Bit-write: write A addr 0x10 din 0x7FFF bw 0x7FFF, then write B addr 0x10 din 0x0000 bw 0x00FF, then read D addr 0x10 -> doutD=0x7F00 with vldD at read cycle+2.
REQ-029 Collision: same cycle, A addr 0x20 din 0x1111 bw 0x7FFF, and C addr 0x20 din 0x2222 bw 0x000F -> word=0x1112, coll=1 for one cycle; read back 0x1112.
REQ-030 Read-before-write: in one cycle, write A addr 0x30 din 0x0ABC (old value 0x0001) and read E addr 0x30 -> doutE=0x0001; a read of 0x30 in the next cycle returns 0x0ABC.
REQ-031 Pipelining/reset: issue reads on D, E and F on 3 consecutive cycles, then assert rst 1 cycle after the last issue -> all vld 0 immediately and no vld pulses afterward; ready=0.
REQ-032 Illegal: with NUMADDR=200, read F at addr 250 in RUN, and separately assert write A during INIT -> err pulses once for each, vldF stays 0, and the memory is unchanged.
